scr1_dmem_arb2: RTL

SCR1_DMEM_ARB2 -- requirements
Module: scr1_dmem_arb2

---
 rtl/scr1_arb_pkg.sv | 12 +
 rtl/scr1_memif_pkg.sv | 22 ++
 rtl/scr1_dmem_arb2.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/scr1_arb_pkg.sv
// Arbiter state encoding and requester indices.
package scr1_arb_pkg;

  typedef enum logic {
    SCR1_DMEM_ARB2_ARB  = 1'b0,
    SCR1_DMEM_ARB2_WAIT = 1'b1
  } type_scr1_dmem_arb2_fsm_e;

  localparam logic SCR1_ARB_M0 = 1'b0;
  localparam logic SCR1_ARB_M1 = 1'b1;

endpackage

// File: rtl/scr1_memif_pkg.sv
// SCR1 memory-interface enums shared by all memory-side blocks.
package scr1_memif_pkg;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
  } type_scr1_mem_width_e;

  // IDLE means no response this cycle; RDY_OK / RDY_ER both end a transaction.
  typedef enum logic [1:0] {
    SCR1_MEM_RESP_IDLE   = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

endpackage

// File: rtl/scr1_dmem_arb2.sv
// Two-requester round-robin arbiter in front of one SCR1 data-memory slave.
// At most one transaction is outstanding; request paths are pure muxes.
`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

module scr1_dmem_arb2
  import scr1_memif_pkg::*;
  import scr1_arb_pkg::*;
#(
  parameter int unsigned AWIDTH = `SCR1_DMEM_AWIDTH,
  parameter int unsigned DWIDTH = `SCR1_DMEM_DWIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // requester 0
  input  logic                 m0_req,
  output logic                 m0_req_ack,
  input  type_scr1_mem_cmd_e   m0_cmd,
  input  type_scr1_mem_width_e m0_width,
  input  logic [AWIDTH-1:0]    m0_addr,
  input  logic [DWIDTH-1:0]    m0_wdata,
  output logic [DWIDTH-1:0]    m0_rdata,
  output type_scr1_mem_resp_e  m0_resp,
  // requester 1
  input  logic                 m1_req,
  output logic                 m1_req_ack,
  input  type_scr1_mem_cmd_e   m1_cmd,
  input  type_scr1_mem_width_e m1_width,
  input  logic [AWIDTH-1:0]    m1_addr,
  input  logic [DWIDTH-1:0]    m1_wdata,
  output logic [DWIDTH-1:0]    m1_rdata,
  output type_scr1_mem_resp_e  m1_resp,
  // shared slave
  output logic                 s_req,
  input  logic                 s_req_ack,
  output type_scr1_mem_cmd_e   s_cmd,
  output type_scr1_mem_width_e s_width,
  output logic [AWIDTH-1:0]    s_addr,
  output logic [DWIDTH-1:0]    s_wdata,
  input  logic [DWIDTH-1:0]    s_rdata,
  input  type_scr1_mem_resp_e  s_resp,
  // status
  output logic                 owner_o,
  output logic                 busy_o
);

  type_scr1_dmem_arb2_fsm_e state_q, state_d;
  logic prio_q, prio_d;
  logic owner_q, owner_d;

  logic arb_act;
  logic wait_act;
  logic win;
  logic sel;

  // Winner selection; reset gates every handshake so nothing leaks while rst_n is low.
  always_comb begin
    arb_act  = rst_n & (state_q == SCR1_DMEM_ARB2_ARB);
    wait_act = rst_n & (state_q == SCR1_DMEM_ARB2_WAIT);
    if (m0_req & m1_req) begin
      win = prio_q;
    end else if (m1_req) begin
      win = SCR1_ARB_M1;
    end else begin
      win = SCR1_ARB_M0;
    end
    // Keep the owner's request on the bus while waiting so s_* stays stable.
    sel = arb_act ? win : owner_q;
  end

  // Request-side muxes toward the slave and acks back to the winner.
  always_comb begin
    s_req      = arb_act & (m0_req | m1_req);
    s_cmd      = sel ? m1_cmd   : m0_cmd;
    s_width    = sel ? m1_width : m0_width;
    s_addr     = sel ? m1_addr  : m0_addr;
    s_wdata    = sel ? m1_wdata : m0_wdata;
    m0_req_ack = s_req & (win == SCR1_ARB_M0) & s_req_ack;
    m1_req_ack = s_req & (win == SCR1_ARB_M1) & s_req_ack;
  end

  // Response routing: only the owner sees the slave while waiting; ARB responses are dropped.
  always_comb begin
    m0_resp  = SCR1_MEM_RESP_IDLE;
    m1_resp  = SCR1_MEM_RESP_IDLE;
    m0_rdata = '0;
    m1_rdata = '0;
    if (wait_act) begin
      if (owner_q == SCR1_ARB_M0) begin
        m0_resp  = s_resp;
        m0_rdata = s_rdata;
      end else begin
        m1_resp  = s_resp;
        m1_rdata = s_rdata;
      end
    end
  end

  // Next state: accept in ARB, finish on any non-IDLE response in WAIT.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    unique case (state_q)
      SCR1_DMEM_ARB2_ARB: begin
        if (s_req & s_req_ack) begin
          state_d = SCR1_DMEM_ARB2_WAIT;
          owner_d = win;
        end
      end
      SCR1_DMEM_ARB2_WAIT: begin
        if (s_resp != SCR1_MEM_RESP_IDLE) begin
          state_d = SCR1_DMEM_ARB2_ARB;
          prio_d  = ~owner_q;
        end
      end
      default: state_d = SCR1_DMEM_ARB2_ARB;
    endcase
  end

  // State, priority and owner registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SCR1_DMEM_ARB2_ARB;
      prio_q  <= SCR1_ARB_M0;
      owner_q <= SCR1_ARB_M0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
    end
  end

  assign busy_o  = (state_q == SCR1_DMEM_ARB2_WAIT);
  assign owner_o = owner_q;

endmodule
